// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO on the byte side.
// Latency: a byte is visible on io_out_valid about 3 + 9.5*DIV cycles after the start-bit edge.
// Backpressure: bytes queue in the FIFO; a byte completing while it is full is dropped with io_overrun.

// uart_rx_fifo: generic power-of-two FIFO, registered storage, head shown directly.
// Latency: a push into an empty FIFO shows on out_vld the following cycle.
// Backpressure: in_rdy drops when full, except when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_vld = !empty;
  assign out_dat = mem[rd_ptr[AW-1:0]];
  assign pop     = out_vld && out_rdy;
  assign in_rdy  = !full || pop;
  assign push    = in_vld && in_rdy;

  // Storage and pointer update; a full FIFO with a same-cycle pop still takes the push.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= in_dat;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end
endmodule

// uart_rx: start-bit detect, mid-bit sampling, stop-bit check, FIFO push.
// Latency: push happens on the stop-bit sample; out valid the next cycle.
// Backpressure: io_out_ready pops the FIFO; full FIFO drops new bytes and pulses io_overrun.
module uart_rx #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DEPTH      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_in,
  output logic       io_out_valid,
  input  logic       io_out_ready,
  output logic [7:0] io_out_bits,
  output logic       io_frame_error,
  output logic       io_overrun
);
  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: CLOCK_FREQ / BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    data;
  logic          rx_meta;
  logic          rx_s;
  logic          half_hit;
  logic          bit_hit;
  logic          push_vld;
  logic          push_rdy;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= io_in;
      rx_s    <= rx_meta;
    end
  end

  assign half_hit = (cnt == CW'(DIV / 2 - 1));
  assign bit_hit  = (cnt == CW'(DIV - 1));
  // A good stop bit hands the byte straight to the FIFO in the same cycle.
  assign push_vld = (state == S_STOP) && bit_hit && rx_s;

  // Frame state machine: bit timing, shifting, and the two error pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      data           <= '0;
      io_frame_error <= 1'b0;
      io_overrun     <= 1'b0;
    end else begin
      io_frame_error <= 1'b0;
      io_overrun     <= push_vld && !push_rdy;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          if (half_hit) begin
            cnt <= '0;
            idx <= '0;
            // A start bit gone high by mid-bit is a glitch, not a frame.
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_hit) begin
            data <= {rx_s, data[7:1]};
            cnt  <= '0;
            idx  <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_hit) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              io_frame_error <= 1'b1;
              state          <= S_RECOVER;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RECOVER: begin
          // Wait out a held-low line so a break reports a single error.
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (push_vld),
    .in_dat  (data),
    .in_rdy  (push_rdy),
    .out_vld (io_out_valid),
    .out_rdy (io_out_ready),
    .out_dat (io_out_bits)
  );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx at a short bit period (DIV = 16).
// Latency: observes start-edge-to-valid latency and per-scenario outputs.
// Backpressure: drives io_out_ready low to fill the FIFO and provoke an overrun.
module tb_uart_rx;
  localparam int CLOCK_FREQ = 1600000;
  localparam int BAUD_RATE  = 100000;
  localparam int DEPTH      = 4;
  localparam int DIV        = CLOCK_FREQ / BAUD_RATE;

  logic       clock;
  logic       reset;
  logic       io_in;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [7:0] io_out_bits;
  logic       io_frame_error;
  logic       io_overrun;

  int errors;
  int checks;

  // Monitor history, written only by the monitor process.
  logic [7:0] rx_log [256];
  int         rx_n;
  int         vld_cnt;
  int         fe_cnt;
  int         ov_cnt;

  uart_rx #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DEPTH      (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_in          (io_in),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_bits    (io_out_bits),
    .io_frame_error (io_frame_error),
    .io_overrun     (io_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sample outputs on the falling edge, well away from the active edge.
  always @(negedge clock) begin
    if (io_out_valid) vld_cnt++;
    if (io_out_valid && io_out_ready) begin
      rx_log[rx_n[7:0]] = io_out_bits;
      rx_n++;
    end
    if (io_frame_error) fe_cnt++;
    if (io_overrun) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    io_in = 1'b0;
    tick(DIV);
    for (int i = 0; i < nbits; i++) begin
      io_in = b[i];
      tick(DIV);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_partial(b, 8);
    io_in = stop_bit;
    tick(DIV);
    io_in = 1'b1;
  endtask

  int rx_base;
  int vld_base;
  int fe_base;
  int ov_base;
  int lat;

  task automatic mark();
    rx_base  = rx_n;
    vld_base = vld_cnt;
    fe_base  = fe_cnt;
    ov_base  = ov_cnt;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rx_n         = 0;
    vld_cnt      = 0;
    fe_cnt       = 0;
    ov_cnt       = 0;
    io_in        = 1'b1;
    io_out_ready = 1'b1;
    reset        = 1'b1;
    tick(3);

    // Reset state of the outputs.
    check("rst_valid", 32'(io_out_valid), 32'd0);
    check("rst_bits", 32'(io_out_bits), 32'h00);
    check("rst_frame_error", 32'(io_frame_error), 32'd0);
    check("rst_overrun", 32'(io_overrun), 32'd0);
    reset = 1'b0;
    tick(5);

    // Single byte with ready high: latency window 2 + 9.5*DIV = 154, +/-2.
    mark();
    lat = 0;
    fork
      send_byte(8'h41, 1'b1);
      begin
        while (!io_out_valid && lat < 400) begin
          tick(1);
          lat++;
        end
      end
    join
    tick(DIV);
    check("latency_in_window", 32'(lat >= 152 && lat <= 156), 32'd1);
    check("b41_count", 32'(rx_n - rx_base), 32'd1);
    check("b41_value", 32'(rx_log[rx_base[7:0]]), 32'h41);
    check("b41_valid_cycles", 32'(vld_cnt - vld_base), 32'd1);
    check("b41_no_ferr", 32'(fe_cnt - fe_base), 32'd0);
    check("b41_no_ovr", 32'(ov_cnt - ov_base), 32'd0);

    // Ready low: five back-to-back bytes, the fifth overruns the FIFO.
    mark();
    io_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h41 + i), 1'b1);
    end
    tick(2 * DIV);
    check("ovr_pulses", 32'(ov_cnt - ov_base), 32'd1);
    check("ovr_nothing_popped", 32'(rx_n - rx_base), 32'd0);
    check("ovr_valid_held", 32'(io_out_valid), 32'd1);
    check("ovr_head_held", 32'(io_out_bits), 32'h41);
    io_out_ready = 1'b1;
    tick(10);
    check("drain_count", 32'(rx_n - rx_base), 32'd4);
    check("drain_0", 32'(rx_log[8'(rx_base + 0)]), 32'h41);
    check("drain_1", 32'(rx_log[8'(rx_base + 1)]), 32'h42);
    check("drain_2", 32'(rx_log[8'(rx_base + 2)]), 32'h43);
    check("drain_3", 32'(rx_log[8'(rx_base + 3)]), 32'h44);
    check("drain_empty", 32'(io_out_valid), 32'd0);

    // Bad stop bit, then a good frame.
    mark();
    send_byte(8'h55, 1'b0);
    tick(DIV);
    check("ferr_pulses", 32'(fe_cnt - fe_base), 32'd1);
    check("ferr_no_valid", 32'(vld_cnt - vld_base), 32'd0);
    send_byte(8'hA5, 1'b1);
    tick(DIV);
    check("after_ferr_count", 32'(rx_n - rx_base), 32'd1);
    check("after_ferr_value", 32'(rx_log[rx_base[7:0]]), 32'hA5);

    // Short low glitch on an idle line, then a good frame.
    mark();
    io_in = 1'b0;
    tick(DIV / 4);
    io_in = 1'b1;
    tick(2 * DIV);
    check("glitch_no_valid", 32'(vld_cnt - vld_base), 32'd0);
    check("glitch_no_ferr", 32'(fe_cnt - fe_base), 32'd0);
    send_byte(8'h5A, 1'b1);
    tick(DIV);
    check("after_glitch_count", 32'(rx_n - rx_base), 32'd1);
    check("after_glitch_value", 32'(rx_log[rx_base[7:0]]), 32'h5A);

    // Break: line held low for 20 bit times, then a 0x00 byte.
    mark();
    io_in = 1'b0;
    tick(20 * DIV);
    io_in = 1'b1;
    tick(DIV);
    check("break_ferr_pulses", 32'(fe_cnt - fe_base), 32'd1);
    check("break_no_valid", 32'(vld_cnt - vld_base), 32'd0);
    send_byte(8'h00, 1'b1);
    tick(DIV);
    check("after_break_count", 32'(rx_n - rx_base), 32'd1);
    check("after_break_value", 32'(rx_log[rx_base[7:0]]), 32'h00);
    check("after_break_ferr", 32'(fe_cnt - fe_base), 32'd1);

    // Reset in the middle of bit 4 of 0x3C, then 0xC3.
    mark();
    send_partial(8'h3C, 4);
    io_in = 1'b1;
    tick(DIV / 2);
    reset = 1'b1;
    tick(1);
    check("midrst_valid", 32'(io_out_valid), 32'd0);
    check("midrst_bits", 32'(io_out_bits), 32'h00);
    tick(2);
    reset = 1'b0;
    tick(2 * DIV);
    send_byte(8'hC3, 1'b1);
    tick(DIV);
    check("midrst_count", 32'(rx_n - rx_base), 32'd1);
    check("midrst_value", 32'(rx_log[rx_base[7:0]]), 32'hC3);
    check("midrst_no_ferr", 32'(fe_cnt - fe_base), 32'd0);
    check("midrst_no_ovr", 32'(ov_cnt - ov_base), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: Parameter CLOCK_FREQ, default 100000000, clock frequency in Hz.
REQ-002: Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003: Parameter DEPTH, default 4, receive FIFO depth; power of two, at least 2.
REQ-004: clock  input  1  rising-edge clock for all state.
REQ-005: reset  input  1  reset, synchronous, active-high.
REQ-006: io_in  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-007: io_out_valid  output  1  FIFO non-empty; io_out_bits is a valid byte.
REQ-008: io_out_ready  input  1  consumer accepts the byte when valid and ready are both high.
REQ-009: io_out_bits  output  8  byte at the FIFO head.
REQ-010: io_frame_error  output  1  one-cycle pulse when a stop bit samples low.
REQ-011: io_overrun  output  1  one-cycle pulse when a completed byte is dropped because the FIFO is full.

Function
REQ-012: DIV = CLOCK_FREQ / BAUD_RATE (integer division); DIV >= 4 shall be enforced by an elaboration-time check.
REQ-013: io_in shall pass through a 2-flop synchronizer (both flops reset to 1); its output rx_s is the only use of io_in.
REQ-014: Bit counter width = clog2(DIV); bit index 3 bits.
REQ-015: States: IDLE, START, DATA, STOP, RECOVER.
REQ-016: IDLE: when rx_s == 0, clear the counter and go to START.
REQ-017: START: at counter == DIV/2 - 1, sample rx_s.
- Sample 0: clear counter and bit index, go to DATA.
- Sample 1: treat as a glitch, go to IDLE, no pulse.
REQ-018: DATA: at counter == DIV - 1, shift rx_s into the data register LSB first, clear counter, increment index; after index 7 go to STOP.
REQ-019: STOP: at counter == DIV - 1, sample rx_s.
- Sample 1: push the byte to the FIFO, go to IDLE.
- Sample 0: pulse io_frame_error, discard the byte, go to RECOVER.
REQ-020: RECOVER: stay until rx_s == 1, then go to IDLE; a held-low (break) line yields exactly one io_frame_error.
REQ-021: Counter otherwise increments by 1 per cycle in START/DATA/STOP and holds in IDLE/RECOVER.
REQ-022: FIFO pop occurs on io_out_valid && io_out_ready.
REQ-023: FIFO push is accepted when occupancy < DEPTH, or when a pop occurs in the same cycle (full with simultaneous pop: push accepted, occupancy unchanged).
REQ-024: A push refused because the FIFO is full shall pulse io_overrun; FIFO contents are unchanged.
REQ-025: Read/write pointers are clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty are derived from the pointers.
REQ-026: Push at empty: io_out_valid asserts the next cycle, with io_out_bits equal to the pushed byte (no same-cycle bypass).
REQ-027: io_out_bits is stable while io_out_valid is high and io_out_ready is low.
REQ-028: Simultaneous push and pop at non-full, non-empty: both take effect; byte order is preserved.

Reset
REQ-029: During reset: state IDLE, counter 0, index 0, data register 0x00, FIFO pointers 0, synchronizer flops 1.
REQ-030: During reset: io_out_valid 0, io_frame_error 0, io_overrun 0, io_out_bits 0x00.
REQ-031: Reset asserted mid-frame shall abandon the frame (no push, no pulse); the next frame is received normally after reset deasserts with the line idle.

Verification
REQ-032: Defaults (DIV = 868); ready = 1; send 0x41 -> one valid cycle with bits 0x41, valid rising 2 + 9.5*DIV cycles (±2) after the io_in falling edge.
REQ-033: Ready = 0; send 0x41..0x45 back-to-back -> first 4 bytes 0x41..0x44 held; io_overrun pulses once at 0x45; raising ready drains 0x41, 0x42, 0x43, 0x44 in order, then valid = 0.
REQ-034: Send 0x55 with a stop bit of 0, line then returns high -> one io_frame_error pulse, no valid; next byte 0xA5 received correctly.
REQ-035: io_in low pulse of DIV/4 cycles while idle -> no valid, no error, state back to IDLE.
REQ-036: Hold io_in low for 20*DIV cycles -> exactly one io_frame_error; after release, byte 0x00 received correctly.
REQ-037: Assert reset during bit 4 of 0x3C, then send 0xC3 -> only 0xC3 emitted, no pulses.
